// File: rtl/serial_word_loader_pkg.sv
// Shared types and constants for the serial word loader.
// Defines the frame FSM states and the default word width.
package serial_word_loader_pkg;

  localparam int DEFAULT_N = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } state_e;

endpackage

// File: rtl/serial_word_loader_bit_counter.sv
// Up-counter with synchronous active-low clear, a clear-to-zero input and an increment enable.
module bit_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         zero,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_r;

  // Count register: zero beats increment so a frame can never carry a stale count.
  always_ff @(posedge clk) begin
    if (!clear) begin
      count_r <= {W{1'b0}};
    end else if (zero) begin
      count_r <= {W{1'b0}};
    end else if (inc) begin
      count_r <= count_r + W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/serial_word_loader.sv
// Collects N serial bits into a word and presents it with a one-cycle load strobe
// to a downstream parallel register (word -> x, load -> load).
module serial_word_loader
  import serial_word_loader_pkg::*;
#(
  parameter int N         = DEFAULT_N,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                   clk,
  input  logic                   clear,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   bit_valid,
  input  logic                   bit_in,
  output logic [N-1:0]           word,
  output logic                   load,
  output logic                   busy,
  output logic [$clog2(N+1)-1:0] bit_count
);

  localparam int CW = $clog2(N+1);

  state_e         state_r;
  state_e         next_state_s;
  logic [N-1:0]   shift_r;
  logic [N-1:0]   shift_nxt_s;
  logic [N-1:0]   word_r;
  logic           load_r;
  logic           busy_r;
  logic           accept_s;
  logic           last_s;
  logic           zero_s;
  logic [CW-1:0]  count_s;

  bit_counter #(.W(CW)) u_bit_counter (
    .clk   (clk),
    .clear (clear),
    .zero  (zero_s),
    .inc   (accept_s),
    .count (count_s)
  );

  // Next-state decode; abort wins over both start and bit_valid.
  always_comb begin
    next_state_s = state_r;
    accept_s     = 1'b0;
    last_s       = 1'b0;
    zero_s       = 1'b0;
    if (MSB_FIRST) begin
      shift_nxt_s = {shift_r[N-2:0], bit_in};
    end else begin
      shift_nxt_s = {bit_in, shift_r[N-1:1]};
    end
    case (state_r)
      IDLE: begin
        zero_s = 1'b1;
        if (start && !abort) begin
          next_state_s = SHIFT;
        end else begin
          next_state_s = IDLE;
        end
      end
      SHIFT: begin
        if (abort) begin
          zero_s       = 1'b1;
          next_state_s = IDLE;
        end else if (bit_valid) begin
          accept_s = 1'b1;
          if (count_s == CW'(N - 1)) begin
            last_s       = 1'b1;
            next_state_s = LOAD;
          end else begin
            next_state_s = SHIFT;
          end
        end else begin
          next_state_s = SHIFT;
        end
      end
      LOAD: begin
        zero_s       = 1'b1;
        next_state_s = IDLE;
      end
      default: begin
        zero_s       = 1'b1;
        next_state_s = IDLE;
      end
    endcase
  end

  // State, shift and output registers; word only moves on the edge that takes the Nth bit.
  always_ff @(posedge clk) begin
    if (!clear) begin
      state_r <= IDLE;
      shift_r <= {N{1'b0}};
      word_r  <= {N{1'b0}};
      load_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= next_state_s;
      load_r  <= (next_state_s == LOAD);
      busy_r  <= (next_state_s != IDLE);
      if (accept_s) begin
        shift_r <= shift_nxt_s;
      end else if (zero_s) begin
        shift_r <= {N{1'b0}};
      end else begin
        shift_r <= shift_r;
      end
      if (last_s) begin
        word_r <= shift_nxt_s;
      end else begin
        word_r <= word_r;
      end
    end
  end

  assign word      = word_r;
  assign load      = load_r;
  assign busy      = busy_r;
  assign bit_count = count_s;

endmodule

// File: tb/tb_serial_word_loader.sv
// Directed bench: one MSB-first and one LSB-first instance share the same stimulus.
module tb_serial_word_loader;

  logic       clk = 1'b0;
  logic       clear, start, abort, bit_valid, bit_in;
  logic [7:0] word_m, word_l;
  logic       load_m, load_l, busy_m, busy_l;
  logic [3:0] cnt_m, cnt_l;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         t1;

  typedef struct {
    logic       s;
    logic       a;
    logic       v;
    logic       b;
    logic [7:0] wm;
    logic [7:0] wl;
    logic       ld;
    logic       bsy;
    logic [3:0] cnt;
  } vec_t;

  vec_t vecs[11];
  logic [7:0] pat;

  always #5 clk = ~clk;

  serial_word_loader #(.N(8), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .clear(clear), .start(start), .abort(abort),
    .bit_valid(bit_valid), .bit_in(bit_in),
    .word(word_m), .load(load_m), .busy(busy_m), .bit_count(cnt_m)
  );

  serial_word_loader #(.N(8), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .clear(clear), .start(start), .abort(abort),
    .bit_valid(bit_valid), .bit_in(bit_in),
    .word(word_l), .load(load_l), .busy(busy_l), .bit_count(cnt_l)
  );

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", nm, idx, act, exp);
    end
  endtask

  task automatic apply(input logic s, input logic a, input logic v, input logic b);
    start = s; abort = a; bit_valid = v; bit_in = b;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    // Frame 1 table: bits 1,0,1,1,0,0,1,0 -> B2 (MSB first) / 4D (LSB first)
    pat = 8'b1011_0010;
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 4'd0};
    for (int k = 0; k < 8; k++) begin
      vecs[k+1] = '{(k == 2) ? 1'b1 : 1'b0, 1'b0, 1'b1, pat[7-k],
                    (k == 7) ? 8'hB2 : 8'h00, (k == 7) ? 8'h4D : 8'h00,
                    (k == 7) ? 1'b1 : 1'b0, 1'b1, 4'(k + 1)};
    end
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'hB2, 8'h4D, 1'b0, 1'b0, 4'd0};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'hB2, 8'h4D, 1'b0, 1'b0, 4'd0};

    clear = 1'b0;
    apply(1'b1, 1'b0, 1'b1, 1'b1);
    apply(1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_word", 0, 32'(word_m), 32'h0);
    chk("rst_load", 0, 32'(load_m), 32'h0);
    chk("rst_busy", 0, 32'(busy_m), 32'h0);
    chk("rst_cnt",  0, 32'(cnt_m),  32'h0);
    clear = 1'b1;

    for (int i = 0; i < 11; i++) begin
      apply(vecs[i].s, vecs[i].a, vecs[i].v, vecs[i].b);
      chk("tbl_word_msb", i, 32'(word_m), 32'(vecs[i].wm));
      chk("tbl_word_lsb", i, 32'(word_l), 32'(vecs[i].wl));
      chk("tbl_load",     i, 32'(load_m), 32'(vecs[i].ld));
      chk("tbl_load_lsb", i, 32'(load_l), 32'(vecs[i].ld));
      chk("tbl_busy",     i, 32'(busy_m), 32'(vecs[i].bsy));
      chk("tbl_cnt",      i, 32'(cnt_m),  32'(vecs[i].cnt));
    end

    // abort beats start in IDLE
    apply(1'b1, 1'b1, 1'b0, 1'b0);
    chk("idle_abort_busy", 0, 32'(busy_m), 32'h0);

    // Abort after 5 bits, with bit_valid also high
    apply(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      apply(1'b0, 1'b0, 1'b1, k[0]);
      chk("abort_cnt", k, 32'(cnt_m), 32'(k + 1));
    end
    apply(1'b0, 1'b1, 1'b1, 1'b1);
    chk("abort_cnt0", 0, 32'(cnt_m),  32'h0);
    chk("abort_busy", 0, 32'(busy_m), 32'h0);
    for (int k = 0; k < 3; k++) begin
      chk("abort_noload", k, 32'(load_m), 32'h0);
      chk("abort_word_m", k, 32'(word_m), 32'hB2);
      chk("abort_word_l", k, 32'(word_l), 32'h4D);
      apply(1'b0, 1'b0, 1'b1, 1'b1);
    end

    // clear on the edge that samples the 8th bit
    apply(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 7; k++) apply(1'b0, 1'b0, 1'b1, 1'b1);
    clear = 1'b0;
    apply(1'b0, 1'b0, 1'b1, 1'b1);
    clear = 1'b1;
    chk("clr_word", 0, 32'(word_m), 32'h0);
    chk("clr_busy", 0, 32'(busy_m), 32'h0);
    chk("clr_cnt",  0, 32'(cnt_m),  32'h0);
    for (int k = 0; k < 3; k++) begin
      chk("clr_noload", k, 32'(load_m), 32'h0);
      chk("clr_word_hold", k, 32'(word_m), 32'h0);
      apply(1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Same frame with two idle cycles after every valid bit
    apply(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      apply(1'b0, 1'b0, 1'b1, pat[7-k]);
      chk("gap_cnt", k, 32'(cnt_m), 32'(k + 1));
      if (k < 7) begin
        chk("gap_noload", k, 32'(load_m), 32'h0);
        for (int g = 0; g < 2; g++) begin
          apply(1'b0, 1'b0, 1'b0, ~pat[7-k]);
          chk("gap_stall", k, 32'(cnt_m), 32'(k + 1));
        end
      end else begin
        chk("gap_load",   k, 32'(load_m), 32'h1);
        chk("gap_word_m", k, 32'(word_m), 32'hB2);
        chk("gap_word_l", k, 32'(word_l), 32'h4D);
      end
    end
    apply(1'b0, 1'b0, 1'b0, 1'b0);
    chk("gap_load_end", 0, 32'(load_m), 32'h0);
    chk("gap_busy_end", 0, 32'(busy_m), 32'h0);

    // Back-to-back frames FF then 01, with stray starts during SHIFT
    apply(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) apply((k == 3) ? 1'b1 : 1'b0, 1'b0, 1'b1, 1'b1);
    chk("b2b_load1", 0, 32'(load_m), 32'h1);
    chk("b2b_word1", 0, 32'(word_m), 32'hFF);
    t1 = cyc;
    apply(1'b0, 1'b0, 1'b0, 1'b0);
    chk("b2b_gap_load", 0, 32'(load_m), 32'h0);
    apply(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      apply((k == 2) ? 1'b1 : 1'b0, 1'b0, 1'b1, (k == 7) ? 1'b1 : 1'b0);
      if (k < 7) chk("b2b_noload", k, 32'(load_m), 32'h0);
    end
    chk("b2b_load2",  0, 32'(load_m), 32'h1);
    chk("b2b_word2",  0, 32'(word_m), 32'h01);
    chk("b2b_word2l", 0, 32'(word_l), 32'h80);
    chk("b2b_period", 0, 32'(cyc - t1), 32'd10);
    apply(1'b0, 1'b0, 1'b0, 1'b0);
    chk("b2b_end_load", 0, 32'(load_m), 32'h0);
    chk("b2b_end_busy", 0, 32'(busy_m), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_word_loader.md
SERIAL_WORD_LOADER -- requirements
Module: serial_word_loader

Interface
REQ-001 Parameter N, default 8, word width; legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 1; 1 = first accepted bit lands in word[N-1], 0 = first accepted bit lands in word[0].
REQ-003 clk  input  1  single clock; all state SHALL change only on posedge clk.
REQ-004 clear  input  1  reset, synchronous and active-low; sampled on posedge clk.
REQ-005 start  input  1  request to begin a new frame; honoured only in IDLE.
REQ-006 abort  input  1  discard the frame in progress.
REQ-007 bit_valid  input  1  bit_in is valid this cycle.
REQ-008 bit_in  input  1  serial data bit.
REQ-009 word  output  N  last completed word; registered, drives x of the downstream parametrizable register.
REQ-010 load  output  1  one-cycle strobe, drives load of the downstream register.
REQ-011 busy  output  1  high in SHIFT and LOAD.
REQ-012 bit_count  output  $clog2(N+1)  number of bits accepted in the current frame.

Function
REQ-013 FSM states: IDLE, SHIFT, LOAD; all outputs registered or decoded from registered state only.
REQ-014 IDLE: start=1 and abort=0 -> SHIFT next cycle with bit_count=0; otherwise stay in IDLE.
REQ-015 SHIFT: on bit_valid=1 the shift register takes bit_in per MSB_FIRST and bit_count increments by 1.
REQ-016 SHIFT: bit_valid=0 holds the shift register and bit_count; there is no timeout.
REQ-017 SHIFT: the Nth accepted bit -> word is updated with all N bits on the same edge, then the FSM enters LOAD.
REQ-018 LOAD: load=1 for exactly one cycle, the cycle after the edge that sampled the Nth bit; then IDLE with bit_count=0.
REQ-019 word SHALL hold its value from one LOAD until the next completed frame; an aborted frame never changes word.
REQ-020 abort=1 in SHIFT -> IDLE next cycle, bit_count=0, the partial shift contents are discarded, and load is not asserted.
REQ-021 Priority: abort over bit_valid; abort over start.
REQ-022 abort in LOAD is ignored; the strobe still completes.
REQ-023 bit_valid in IDLE or LOAD is ignored, with no state change.
REQ-024 start in SHIFT or LOAD is ignored, with no restart.
REQ-025 bit_count never exceeds N and wraps to 0 only via LOAD, abort, or reset.
REQ-026 Back-to-back frames: start asserted in the IDLE cycle after LOAD begins a new frame; the minimum frame period is N+2 cycles.

Reset
REQ-027 clear=0 at posedge clk -> state=IDLE, word=0, load=0, busy=0, bit_count=0, shift register=0.
REQ-028 Reset mid-frame (SHIFT or LOAD) SHALL suppress any pending load and leave word=0.
REQ-029 clear has priority over all other inputs; there is no asynchronous path.

Structure
REQ-030 Shared package serial_word_loader_pkg SHALL hold the state enum (IDLE, SHIFT, LOAD) and the default N constant.
REQ-031 One sub-module bit_counter: parametrizable up-counter with synchronous active-low clear, increment enable, and clear-to-zero input; the FSM, shift register, and word register stay in the top.
REQ-032 The top SHALL instantiate cleanly in front of the team's existing n-bit registroPos: word -> x, load -> load, same clk.

Verification
REQ-033 N=8, MSB_FIRST=1: start, then bits 1,0,1,1,0,0,1,0 on consecutive cycles -> word=8'hB2, load high exactly one cycle, busy low afterwards.
REQ-034 N=8, MSB_FIRST=0: same bit sequence -> word=8'h4D.
REQ-035 N=8: 5 bits accepted, then abort -> bit_count=0, IDLE, no load pulse, word unchanged from the prior frame (8'hB2).
REQ-036 N=8: bits presented with bit_valid gaps (1 of every 3 cycles) -> same word as the gap-free case, load one cycle after the 8th valid bit, bit_count stalls during gaps.
REQ-037 clear=0 asserted the cycle the 8th bit is sampled -> no load ever, word=0, IDLE on the next cycle.
REQ-038 Two frames 8'hFF then 8'h01, with start in the cycle after each LOAD -> two load pulses 10 cycles apart, word sequence FF then 01; start pulses during SHIFT are ignored.
